// File: rtl/weight_loader.sv
// weight_loader: parses host weight packets onto the broadcast neuron config bus.
// Latency: an accepted bias or weight word appears on the outputs 1 cycle later; 1 word/cycle.
// Backpressure: s_ready is registered and drops only for the single DONE cycle (and in reset).
//
// Ports:
//   clk, rst (async, active-low)
//   s_data/s_valid/s_ready : host word stream
//   abort                  : synchronous abort of the packet in flight
//   weightValue            : weight word, meaningful only while config IDs differ from IDLE_ID
//   biasValue/bias_valid   : bias of the current packet, plus a one-cycle update pulse
//   config_layer_num       : target layer ID for the weight being presented, else IDLE_ID
//   config_neuron_num      : target neuron ID for the weight being presented, else IDLE_ID
//   busy/done/err          : status; done and err are one-cycle pulses
// Option: define LOADER_CHECKSUM_EN to expect a trailing XOR check word per packet.
module weight_loader #(
  parameter int          MAX_NUM_WEIGHT = 784,
  parameter int          NUM_LAYERS     = 4,
  parameter logic [31:0] IDLE_ID        = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        abort,
  output logic [31:0] weightValue,
  output logic [31:0] biasValue,
  output logic        bias_valid,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BIAS    = 3'd1,
    WEIGHTS = 3'd2,
    CHECK   = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  // State entered once the payload (bias + weights) is exhausted.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHECK;
`else
  localparam state_t END_ST = DONE;
`endif
  localparam logic END_IS_DONE = (END_ST == DONE);

  localparam logic [15:0] MAX_CNT   = 16'(MAX_NUM_WEIGHT);
  localparam logic [7:0]  LAYER_LIM = 8'(NUM_LAYERS);

  state_t      state;
  logic [15:0] remaining;
  logic [7:0]  layer_id;
  logic [7:0]  neuron_id;
  logic        accept;
  logic        hdr_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  assign accept  = s_valid & s_ready;
  assign hdr_bad = (s_data[15:0] > MAX_CNT) || (s_data[31:24] >= LAYER_LIM);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      remaining         <= 16'd0;
      layer_id          <= 8'd0;
      neuron_id         <= 8'd0;
      s_ready           <= 1'b0;
      weightValue       <= 32'd0;
      biasValue         <= 32'd0;
      bias_valid        <= 1'b0;
      config_layer_num  <= IDLE_ID;
      config_neuron_num <= IDLE_ID;
      done              <= 1'b0;
      err               <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum              <= 32'd0;
`endif
    end else begin
      // Pulses and IDs fall back every cycle unless a branch below drives them.
      done              <= 1'b0;
      err               <= 1'b0;
      bias_valid        <= 1'b0;
      config_layer_num  <= IDLE_ID;
      config_neuron_num <= IDLE_ID;
      s_ready           <= 1'b1;

      if (abort) begin
        // A weight taken in the abort cycle was already handshaken, so still present it.
        if (state == WEIGHTS && accept) begin
          weightValue       <= s_data;
          config_layer_num  <= {24'd0, layer_id};
          config_neuron_num <= {24'd0, neuron_id};
        end
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            layer_id  <= s_data[31:24];
            neuron_id <= s_data[23:16];
            remaining <= s_data[15:0];
`ifdef LOADER_CHECKSUM_EN
            csum      <= s_data;
`endif
            if (hdr_bad) begin
              err   <= 1'b1;
              state <= DRAIN;
            end else begin
              state <= BIAS;
            end
          end

          BIAS: if (accept) begin
            biasValue  <= s_data;
            bias_valid <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum       <= csum ^ s_data;
`endif
            if (remaining == 16'd0) begin
              state   <= END_ST;
              s_ready <= !END_IS_DONE;
              done    <= END_IS_DONE;
            end else begin
              state <= WEIGHTS;
            end
          end

          WEIGHTS: if (accept) begin
            weightValue       <= s_data;
            config_layer_num  <= {24'd0, layer_id};
            config_neuron_num <= {24'd0, neuron_id};
`ifdef LOADER_CHECKSUM_EN
            csum              <= csum ^ s_data;
`endif
            if (remaining != 16'd0)
              remaining <= remaining - 16'd1;
            if (remaining <= 16'd1) begin
              state   <= END_ST;
              s_ready <= !END_IS_DONE;
              done    <= END_IS_DONE;
            end
          end

`ifdef LOADER_CHECKSUM_EN
          CHECK: if (accept) begin
            if (s_data == csum) begin
              state   <= DONE;
              s_ready <= 1'b0;
              done    <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
`endif

          // Rejected packet: swallow bias plus 'count' weights without driving the bus.
          DRAIN: if (accept) begin
            if (remaining == 16'd0)
              state <= IDLE;
            else
              remaining <= remaining - 16'd1;
          end

          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed bench for weight_loader.
// Latency: n/a (bench).
// Backpressure: the send task waits, bounded, for s_ready before each word.
module tb_weight_loader;

  localparam logic [31:0] IDLE_ID = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        abort = 1'b0;
  logic        s_ready;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic        bias_valid;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        done;
  logic        err;

  weight_loader dut (
    .clk               (clk),
    .rst               (rst),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .abort             (abort),
    .weightValue       (weightValue),
    .biasValue         (biasValue),
    .bias_valid        (bias_valid),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bus monitor, sampled mid-cycle.
  int          cyc = 0;
  logic [31:0] wq_dat[$];
  logic [31:0] wq_lay[$];
  logic [31:0] wq_neu[$];
  int          wq_cyc[$];
  int          done_n = 0;
  int          done_cyc = 0;
  int          err_n = 0;
  int          bv_n = 0;

  always @(negedge clk) begin
    cyc++;
    if (config_layer_num !== IDLE_ID) begin
      wq_dat.push_back(weightValue);
      wq_lay.push_back(config_layer_num);
      wq_neu.push_back(config_neuron_num);
      wq_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    if (err === 1'b1) err_n++;
    if (bias_valid === 1'b1) bv_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    ok      = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    s_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: observed no s_ready expected s_ready for word %h", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Trailing check word; only exists when the checksum option is built in.
  task automatic finish_pkt(input logic [31:0] x);
`ifdef LOADER_CHECKSUM_EN
    send(x);
`else
    if (x == 32'hDEAD_BEEF) $display("unused check word");
`endif
  endtask

  int wb, db, eb, bb;

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_weight", weightValue, 32'd0);
    chk("rst_bias", biasValue, 32'd0);
    chk("rst_layer", config_layer_num, IDLE_ID);
    chk("rst_neuron", config_neuron_num, IDLE_ID);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    chk("post_rst_ready", {31'd0, s_ready}, 32'd1);

    // ---- basic packet, back-to-back ----
    wb = wq_dat.size(); db = done_n; eb = err_n; bb = bv_n;
    send(32'h0102_0003);
    send(32'h0000_0100);
    send(32'h11);
    send(32'h22);
    send(32'h33);
    finish_pkt(32'h0102_0103);
    idle(3);
    chk("p1_wcount", 32'(wq_dat.size() - wb), 32'd3);
    chk("p1_w0", wq_dat[wb], 32'h11);
    chk("p1_w1", wq_dat[wb+1], 32'h22);
    chk("p1_w2", wq_dat[wb+2], 32'h33);
    chk("p1_layer", wq_lay[wb], 32'd1);
    chk("p1_neuron", wq_neu[wb+2], 32'd2);
    chk("p1_consec01", 32'(wq_cyc[wb+1] - wq_cyc[wb]), 32'd1);
    chk("p1_consec12", 32'(wq_cyc[wb+2] - wq_cyc[wb+1]), 32'd1);
    chk("p1_bias", biasValue, 32'h100);
    chk("p1_bias_pulses", 32'(bv_n - bb), 32'd1);
    chk("p1_done", 32'(done_n - db), 32'd1);
    chk("p1_err", 32'(err_n - eb), 32'd0);
`ifndef LOADER_CHECKSUM_EN
    chk("p1_done_timing", 32'(done_cyc), 32'(wq_cyc[wb+2]));
`endif
    chk("p1_busy", {31'd0, busy}, 32'd0);

    // ---- same packet with 2-cycle gaps between weights ----
    wb = wq_dat.size(); db = done_n;
    send(32'h0102_0003);
    send(32'h0000_0100);
    send(32'h11); idle(2);
    chk("gap_ids_idle", config_layer_num, IDLE_ID);
    send(32'h22); idle(2);
    send(32'h33);
    finish_pkt(32'h0102_0103);
    idle(3);
    chk("gap_wcount", 32'(wq_dat.size() - wb), 32'd3);
    chk("gap_spacing", 32'(wq_cyc[wb+1] - wq_cyc[wb]), 32'd3);
    chk("gap_w2", wq_dat[wb+2], 32'h33);
    chk("gap_done", 32'(done_n - db), 32'd1);

    // ---- oversize count: err, 786 words swallowed ----
    wb = wq_dat.size(); db = done_n; eb = err_n; bb = bv_n;
    send(32'h0000_0311);
    for (int i = 0; i < 785; i++) send(32'hA5A5_0000 + 32'(i));
    chk("drain_busy_before_last", {31'd0, busy}, 32'd1);
    send(32'h5A5A_5A5A);
    chk("drain_busy_after_last", {31'd0, busy}, 32'd0);
    idle(2);
    chk("drain_err", 32'(err_n - eb), 32'd1);
    chk("drain_no_weights", 32'(wq_dat.size() - wb), 32'd0);
    chk("drain_no_bias", 32'(bv_n - bb), 32'd0);
    chk("drain_no_done", 32'(done_n - db), 32'd0);

    // ---- layer out of range ----
    eb = err_n;
    send(32'h0400_0001);
    send(32'h1);
    send(32'h2);
    idle(2);
    chk("layer4_err", 32'(err_n - eb), 32'd1);
    chk("layer4_busy", {31'd0, busy}, 32'd0);

    // ---- count==0 packet: bias then done, no weights ----
    wb = wq_dat.size(); db = done_n;
    send(32'h0102_0000);
    send(32'h0000_0005);
    finish_pkt(32'h0102_0005);
    idle(3);
    chk("cnt0_done", 32'(done_n - db), 32'd1);
    chk("cnt0_wcount", 32'(wq_dat.size() - wb), 32'd0);
    chk("cnt0_bias", biasValue, 32'h5);

    // ---- abort after 2 of 3 weights ----
    wb = wq_dat.size(); db = done_n; eb = err_n;
    send(32'h0102_0003);
    send(32'h0000_0100);
    send(32'h11);
    send(32'h22);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    idle(3);
    chk("abort_wcount", 32'(wq_dat.size() - wb), 32'd2);
    chk("abort_no_done_err", 32'((done_n - db) + (err_n - eb)), 32'd0);
    wb = wq_dat.size(); db = done_n;
    send(32'h0203_0003);
    send(32'h0000_0100);
    send(32'h11);
    send(32'h22);
    send(32'h33);
    finish_pkt(32'h0203_0103);
    idle(3);
    chk("after_abort_wcount", 32'(wq_dat.size() - wb), 32'd3);
    chk("after_abort_layer", wq_lay[wb], 32'd2);
    chk("after_abort_done", 32'(done_n - db), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // ---- bad check word ----
    db = done_n; eb = err_n;
    send(32'h0102_0003);
    send(32'h0000_0100);
    send(32'h11);
    send(32'h22);
    send(32'h33);
    send(32'h0);
    idle(3);
    chk("csum_bad_err", 32'(err_n - eb), 32'd1);
    chk("csum_bad_no_done", 32'(done_n - db), 32'd0);
`endif

    // ---- reset mid-WEIGHTS ----
    send(32'h0102_0003);
    send(32'h0000_0100);
    send(32'h11);
    chk("pre_rst_layer", config_layer_num, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_weight", weightValue, 32'd0);
    chk("mid_rst_bias", biasValue, 32'd0);
    chk("mid_rst_layer", config_layer_num, IDLE_ID);
    chk("mid_rst_neuron", config_neuron_num, IDLE_ID);
    chk("mid_rst_ready_busy", {30'd0, s_ready, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    chk("rel_ready", {31'd0, s_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
